// File: rtl/dmem_arbiter.sv
// Two-requester (core C / DMA D) arbiter for the single data memory port, with bounded-burst fairness.
// Latency: grant is combinational in the request cycle; read data returns registered one cycle after the grant.
// Backpressure: a requester holds its request until it sees gnt; the core gets c_stall while it waits.
// Optional DMEM_ARB_PERF_EN adds saturating stall/grant counters; when undefined, the perf outputs are tied to 0.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    // core requester
    input  logic          c_req,
    input  logic          c_we,
    input  logic [1:0]    c_byte,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_stall,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    // DMA requester
    input  logic          d_req,
    input  logic          d_we,
    input  logic [1:0]    d_byte,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    // shared memory port
    output logic          m_we,
    output logic [1:0]    m_byte,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    // performance counters
    output logic [31:0]   perf_cstall,
    output logic [31:0]   perf_dgnt
);

    localparam int             CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_BURST);

    // last owner: 0 = core, 1 = DMA; cnt = consecutive grants to that owner
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          c_rvalid_q, c_rvalid_d;
    logic          d_rvalid_q, d_rvalid_d;
    logic [DW-1:0] c_rdata_q, c_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    // Grant selection; forced off while reset is held low so no write can slip through
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (reset) begin
            if (c_req && d_req) begin
                // the current owner keeps the port until its burst allowance runs out
                if (cnt_q < CNT_MAX) begin
                    c_gnt = ~last_q;
                    d_gnt = last_q;
                end else begin
                    c_gnt = last_q;
                    d_gnt = ~last_q;
                end
            end else begin
                c_gnt = c_req;
                d_gnt = d_req;
            end
        end
    end

    assign c_stall = c_req & ~c_gnt;

    // Memory port mux: DMA fields only when DMA owns the cycle, core fields otherwise (including idle)
    always_comb begin
        m_addr  = c_addr;
        m_byte  = c_byte;
        m_wdata = c_wdata;
        if (d_gnt) begin
            m_addr  = d_addr;
            m_byte  = d_byte;
            m_wdata = d_wdata;
        end
        m_we = (c_gnt & c_we) | (d_gnt & d_we);
    end

    // Ownership/burst tracking: same owner extends the run, new owner restarts it, idle cycle clears it
    always_comb begin
        last_d = last_q;
        cnt_d  = cnt_q;
        if (c_gnt || d_gnt) begin
            if (d_gnt == last_q) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            end else begin
                last_d = d_gnt;
                cnt_d  = CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Read return: capture memory data on a read grant, pulse valid for one cycle, hold data until the next read
    always_comb begin
        c_rvalid_d = c_gnt & ~c_we;
        d_rvalid_d = d_gnt & ~d_we;
        c_rdata_d  = c_rvalid_d ? m_rdata : c_rdata_q;
        d_rdata_d  = d_rvalid_d ? m_rdata : d_rdata_q;
    end

    // Arbiter and response registers; reset drops any in-flight read response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q     <= 1'b0;
            cnt_q      <= '0;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            c_rdata_q  <= c_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign c_rvalid = c_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign d_rdata  = d_rdata_q;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_cstall_q, perf_cstall_d;
    logic [31:0] perf_dgnt_q, perf_dgnt_d;

    // Saturating event counters for core stall cycles and DMA grant cycles
    always_comb begin
        perf_cstall_d = perf_cstall_q;
        perf_dgnt_d   = perf_dgnt_q;
        if (c_stall && (perf_cstall_q != 32'hFFFF_FFFF)) perf_cstall_d = perf_cstall_q + 32'd1;
        if (d_gnt   && (perf_dgnt_q   != 32'hFFFF_FFFF)) perf_dgnt_d   = perf_dgnt_q   + 32'd1;
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cstall_q <= '0;
            perf_dgnt_q   <= '0;
        end else begin
            perf_cstall_q <= perf_cstall_d;
            perf_dgnt_q   <= perf_dgnt_d;
        end
    end

    assign perf_cstall = perf_cstall_q;
    assign perf_dgnt   = perf_dgnt_q;
`else
    assign perf_cstall = '0;
    assign perf_dgnt   = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized + directed bench for dmem_arbiter with a queue-based scoreboard and an abstract reference model.
// Inputs change 1ns after the rising edge; all DUT outputs are sampled on the falling edge.
// Requesters obey hold-until-grant, with occasional withdrawals.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          c_req, c_we, d_req, d_we;
    logic [1:0]    c_byte, d_byte;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;
    logic          c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid;
    logic [DW-1:0] c_rdata, d_rdata;
    logic          m_we;
    logic [1:0]    m_byte;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [31:0]   perf_cstall, perf_dgnt;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_byte(c_byte), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_we(m_we), .m_byte(m_byte), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .perf_cstall(perf_cstall), .perf_dgnt(perf_dgnt)
    );

    // simple word memory behind the port (16 words)
    logic [DW-1:0] mem [0:15];
    assign m_rdata = mem[m_addr[5:2]];
    always @(posedge clk) if (m_we) mem[m_addr[5:2]] <= m_wdata;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int cyc; logic [DW-1:0] dat; } rsp_t;
    rsp_t          cq[$];
    rsp_t          dq[$];
    logic [DW-1:0] ref_mem [16];
    int            owner = 0;   // 0 core, 1 DMA
    int            run   = 0;   // consecutive grants to owner
    int            n_stall = 0;
    int            n_dgnt  = 0;
    string         gnt_log = "";

    // predict grants and the memory port, then advance the model for this cycle's edge
    always @(negedge clk) begin
        int w;
        w = -1;
        if (reset) begin
            if (c_req && d_req) w = (run < MB) ? owner : 1 - owner;
            else if (c_req)     w = 0;
            else if (d_req)     w = 1;
        end
        chk("c_gnt",   64'(c_gnt),   64'(w == 0));
        chk("d_gnt",   64'(d_gnt),   64'(w == 1));
        chk("c_stall", 64'(c_stall), 64'(c_req && w != 0));
        chk("m_we",    64'(m_we),    64'((w == 0 && c_we) || (w == 1 && d_we)));
        if (w == 0) begin
            chk("m_addr_c",  64'(m_addr),  64'(c_addr));
            chk("m_wdata_c", 64'(m_wdata), 64'(c_wdata));
            chk("m_byte_c",  64'(m_byte),  64'(c_byte));
        end else if (w == 1) begin
            chk("m_addr_d",  64'(m_addr),  64'(d_addr));
            chk("m_wdata_d", 64'(m_wdata), 64'(d_wdata));
            chk("m_byte_d",  64'(m_byte),  64'(d_byte));
        end
`ifdef DMEM_ARB_PERF_EN
        chk("perf_cstall", 64'(perf_cstall), reset ? 64'(n_stall) : 64'd0);
        chk("perf_dgnt",   64'(perf_dgnt),   reset ? 64'(n_dgnt)  : 64'd0);
`else
        chk("perf_cstall", 64'(perf_cstall), 64'd0);
        chk("perf_dgnt",   64'(perf_dgnt),   64'd0);
`endif
        if (!reset) begin
            owner = 0; run = 0; n_stall = 0; n_dgnt = 0;
            cq.delete(); dq.delete();
        end else begin
            if (c_req && w != 0) n_stall++;
            if (w == 1) n_dgnt++;
            gnt_log = {gnt_log, (w == 0) ? "C" : (w == 1) ? "D" : "-"};
            if (w < 0) run = 0;
            else if (w == owner) run = (run < MB) ? run + 1 : MB;
            else begin owner = w; run = 1; end
            if (w == 0) begin
                if (c_we) ref_mem[c_addr[5:2]] = c_wdata;
                else      cq.push_back('{cyc + 1, ref_mem[c_addr[5:2]]});
            end else if (w == 1) begin
                if (d_we) ref_mem[d_addr[5:2]] = d_wdata;
                else      dq.push_back('{cyc + 1, ref_mem[d_addr[5:2]]});
            end
        end
    end

    // ---------------- response monitor ----------------
    logic [DW-1:0] exp_crd = '0;
    logic [DW-1:0] exp_drd = '0;
    always @(negedge clk) begin
        bit ev;
        rsp_t r;
        if (!reset) begin
            exp_crd = '0; exp_drd = '0;
            chk("c_rvalid_rst", 64'(c_rvalid), 64'd0);
            chk("d_rvalid_rst", 64'(d_rvalid), 64'd0);
            chk("c_rdata_rst",  64'(c_rdata),  64'd0);
            chk("d_rdata_rst",  64'(d_rdata),  64'd0);
        end else begin
            while (cq.size() > 0 && cq[0].cyc < cyc) void'(cq.pop_front());
            while (dq.size() > 0 && dq[0].cyc < cyc) void'(dq.pop_front());
            ev = (cq.size() > 0 && cq[0].cyc == cyc);
            chk("c_rvalid", 64'(c_rvalid), 64'(ev));
            if (ev && c_rvalid) begin r = cq.pop_front(); exp_crd = r.dat; end
            chk("c_rdata", 64'(c_rdata), 64'(exp_crd));
            ev = (dq.size() > 0 && dq[0].cyc == cyc);
            chk("d_rvalid", 64'(d_rvalid), 64'(ev));
            if (ev && d_rvalid) begin r = dq.pop_front(); exp_drd = r.dat; end
            chk("d_rdata", 64'(d_rdata), 64'(exp_drd));
        end
    end

    // grant seen at the falling edge, used only to pace the random requesters
    logic c_took = 1'b0, d_took = 1'b0;
    always @(negedge clk) begin c_took = c_gnt; d_took = d_gnt; end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit cr, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input bit dr, input bit dw, input logic [AW-1:0] da, input logic [DW-1:0] dd);
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd; c_byte = 2'b10;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_byte = 2'b01;
        step();
    endtask

    initial begin
        reset = 1'b0;
        c_req = 0; c_we = 0; c_byte = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_byte = 0; d_addr = 0; d_wdata = 0;
        for (int i = 0; i < 16; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        step(); step();
        reset = 1'b1;

        // core write then read-back of the same word
        drv(1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0);
        drv(1, 0, 32'h10, 32'h0,         0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("c_rdata_deadbeef", 64'(c_rdata), 64'hDEAD_BEEF);

        // DMA write, then core reads what the DMA left
        drv(0, 0, 0, 0,      1, 1, 32'h20, 32'h5);
        drv(1, 0, 32'h20, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("c_rdata_dma_word", 64'(c_rdata), 64'h5);

        // preload and alternate back-to-back reads
        drv(1, 1, 32'h0, 32'h11, 0, 0, 0, 0);
        drv(0, 0, 0, 0,          1, 1, 32'h4, 32'h22);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) drv(1, 0, 32'h0, 0, 0, 0, 0, 0);
            else            drv(0, 0, 0, 0,     1, 0, 32'h4, 0);
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("c_rdata_alt", 64'(c_rdata), 64'h11);
        chk("d_rdata_alt", 64'(d_rdata), 64'h22);

        // reset right after a core read grant; then 10 contended cycles from fresh state
        drv(1, 0, 32'h0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        c_req = 0;
        step(); step();
        c_req = 1; c_we = 0; c_addr = 32'h0; d_req = 1; d_we = 0; d_addr = 32'h4;
        gnt_log = "";
        reset = 1'b1;
        repeat (10) step();
        c_req = 0; d_req = 0;
        @(negedge clk);
        checks++;
        if (gnt_log != "CCCCDDDDCC") begin
            errors++;
            $display("FAIL grant_seq: got %s expected CCCCDDDDCC", gnt_log);
        end
`ifdef DMEM_ARB_PERF_EN
        chk("perf_dgnt_10",   64'(perf_dgnt),   64'd4);
        chk("perf_cstall_10", 64'(perf_cstall), 64'd4);
`else
        chk("perf_dgnt_off",   64'(perf_dgnt),   64'd0);
        chk("perf_cstall_off", 64'(perf_cstall), 64'd0);
`endif
        step();

        // randomized traffic with hold-until-grant and occasional withdrawal
        for (int n = 0; n < 3000; n++) begin
            if (!c_req || c_took) begin
                c_req = ($urandom_range(0, 99) < 65);
                c_we = $urandom_range(0, 1) == 1; c_byte = 2'($urandom_range(0, 3));
                c_addr = AW'($urandom_range(0, 15) * 4); c_wdata = $urandom;
            end else if ($urandom_range(0, 99) < 5) c_req = 0;
            if (!d_req || d_took) begin
                d_req = ($urandom_range(0, 99) < 65);
                d_we = $urandom_range(0, 1) == 1; d_byte = 2'($urandom_range(0, 3));
                d_addr = AW'($urandom_range(0, 15) * 4); d_wdata = $urandom;
            end else if ($urandom_range(0, 99) < 5) d_req = 0;
            if (n == 1500) begin
                reset = 1'b0;
                step();
                reset = 1'b1;
            end
            step();
        end
        c_req = 0; d_req = 0;
        step(); step(); step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter for the single data memory port.
- Requester C is the pipelined core's load/store port (ALUResultM/WriteDataM/MemWriteM/ByteAccessM path). Requester D is a DMA/loader master that fills or inspects data memory while the core runs.
- Grants at most one access per cycle, drives the shared memory port and returns registered read data with valid strobes.
- Generates the core stall indication when the core loses arbitration.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_BURST, 4, maximum consecutive grants to one requester while the other is waiting (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- c_req  in  1  core access request
- c_we  in  1  core write enable (0 = read)
- c_byte  in  2  core byte-access code, passed through unmodified
- c_addr  in  AW  core address
- c_wdata  in  DW  core write data
- c_gnt  out  1  core granted this cycle
- c_stall  out  1  c_req & ~c_gnt
- c_rvalid  out  1  core read data valid
- c_rdata  out  DW  core read data
- d_req, d_we, d_byte, d_addr, d_wdata  in  1/1/2/AW/DW  DMA request fields, same meaning as core
- d_gnt  out  1  DMA granted this cycle
- d_rvalid  out  1  DMA read data valid
- d_rdata  out  DW  DMA read data
- m_we  out  1  memory write enable
- m_byte  out  2  memory byte-access code
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data, combinational from m_addr

Behaviour:
- State registers: last (0 = C, 1 = D), cnt (0..MAX_BURST, saturating).
- Grant (combinational from req and state):
  - Only one requester requesting → that requester is granted.
  - Both requesting → last owner is granted if cnt < MAX_BURST; otherwise the other requester is granted.
  - Neither requesting → no grant.
  - c_gnt and d_gnt are never both 1.
- State update at clk edge:
  - Grant to same requester as last → cnt = min(cnt+1, MAX_BURST).
  - Grant to other requester → last = new owner, cnt = 1.
  - No grant → cnt = 0, last unchanged.
- Memory port: m_addr/m_byte/m_wdata are muxed from the granted requester (from C when idle). m_we = (c_gnt&c_we) | (d_gnt&d_we). A write commits at the edge ending the grant cycle.
- Read return:
  - On a grant with we = 0, m_rdata is captured at the edge.
  - Owner's rvalid = 1 for exactly the next cycle. rdata is registered and held until the next read response to that requester.
  - Latency: 1 cycle from grant to rvalid.
- Handshake:
  - A requester holds req and all fields stable until it sees gnt.
  - Deasserting req before gnt withdraws the request with no side effects.
  - A new request may be issued in the cycle after gnt, including back-to-back every cycle.
- Simultaneous events: a read grant in cycle N and another grant in cycle N+1 both produce responses. Back-to-back reads give one rvalid per cycle.
- Reset asserted (any time, including mid-burst):
  - last = C, cnt = 0.
  - c_rvalid = d_rvalid = 0; c_rdata = d_rdata = 0.
  - c_gnt = d_gnt = m_we = 0, forced combinationally while reset is low.
  - A pending read response is dropped.
- First cycle after reset release: both requesting → C is granted.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_cstall (32) and perf_dgnt (32).
  - perf_cstall counts cycles with c_stall = 1; perf_dgnt counts d_gnt cycles.
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- Undefined: both outputs exist and are tied to 0; no counter flops are synthesized.

Test Plan:
- Core only: c_req write, addr 0x10, data 0xDEADBEEF, then read 0x10 → c_gnt both cycles, m_we = 1 in the first cycle only, c_rvalid one cycle later with c_rdata = 0xDEADBEEF, c_stall = 0 throughout.
- Both requesters held continuously (MAX_BURST = 4) → grant sequence C,C,C,C,D,D,D,D,C,…; c_stall = 1 exactly in the D cycles.
- DMA writes 0x5 to 0x20 while the core waits, then the core reads 0x20 → c_rdata = 0x5; d_rvalid never asserts.
- Back-to-back reads alternating C/D at 0x0 = 0x11 and 0x4 = 0x22 → rvalid pulses on alternate cycles to the correct requester with the correct data; no cross-delivery.
- Reset asserted the cycle after a core read grant → c_rvalid stays 0; after release both requesting → C granted first; cnt restarts from 0.
- With DMEM_ARB_PERF_EN: 10 contended cycles at MAX_BURST = 4 starting fresh → perf_dgnt = 4, perf_cstall = 4. Without the macro: both outputs = 0.
